// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared definitions for the register-file write-back arbiter:
//   REG_ADDR_W  - register address width (32 architectural registers)
//   ZERO_REG    - hard-wired zero register, never actually written
//   wb_state_e  - write-back staging state (IDLE / COMMIT)
//   reg_is_live - true when a destination register really gets written
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } wb_state_e;

    function automatic logic reg_is_live(input logic [REG_ADDR_W-1:0] addr);
        return addr != ZERO_REG;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the two write-back requester channels, the register-file read
// addresses and the register-file write side of the arbiter.
//   master modport : requester / register-file side (drives requests)
//   slave  modport : arbiter side (drives readies, write port, stall, count)
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32
);
    import regfile_wb_arbiter_pkg::*;

    logic                  ReqValid0;
    logic [REG_ADDR_W-1:0] ReqReg0;
    logic [DATA_W-1:0]     ReqData0;
    logic                  ReqReady0;

    logic                  ReqValid1;
    logic [REG_ADDR_W-1:0] ReqReg1;
    logic [DATA_W-1:0]     ReqData1;
    logic                  ReqReady1;

    logic [REG_ADDR_W-1:0] ReadRegister1;
    logic [REG_ADDR_W-1:0] ReadRegister2;

    logic [REG_ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0]     WriteData;
    logic                  RegWrite;
    logic                  Stall;
    logic [7:0]            WriteCount;

    modport master (
        output ReqValid0, ReqReg0, ReqData0,
        input  ReqReady0,
        output ReqValid1, ReqReg1, ReqData1,
        input  ReqReady1,
        output ReadRegister1, ReadRegister2,
        input  WriteRegister, WriteData, RegWrite, Stall, WriteCount
    );

    modport slave (
        input  ReqValid0, ReqReg0, ReqData0,
        output ReqReady0,
        input  ReqValid1, ReqReg1, ReqData1,
        output ReqReady1,
        input  ReadRegister1, ReadRegister2,
        output WriteRegister, WriteData, RegWrite, Stall, WriteCount
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way grant logic. Grants are combinational from the valids and a
// priority pointer; the pointer flips to the other requester after each
// grant so that, under contention, the one not granted most recently wins.
// With FIXED_PRIO != 0 requester 0 wins every contention.
//   clk, rst_n      : clock, asynchronous active-low reset
//   valid0, valid1  : request pending
//   grant0, grant1  : one-hot (or zero) grant, forced low during reset
// -----------------------------------------------------------------------------
module rr_arbiter2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    // 1 = requester 1 is favoured at the next contention
    logic favor1_q;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (valid0 && valid1) begin
                if ((FIXED_PRIO != 0) || !favor1_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favor1_q <= 1'b0;
        end else if (grant0) begin
            favor1_q <= 1'b1;
        end else if (grant1) begin
            favor1_q <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Merges write-backs from the ALU (requester 0) and the load unit
// (requester 1) into the single register-file write port. An accepted
// request is staged for one cycle (COMMIT) and written at the end of it,
// giving one write per cycle when requests arrive back to back.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   bus (slave)  : requester handshakes, read addresses, write port,
//                  read-after-write Stall and committed-write counter
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic           Clk,
    input  logic           Reset_n,
    regfile_wb_arbiter_if.slave bus
);

    logic grant0;
    logic grant1;
    logic xfer;

    rr_arbiter2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk   (Clk),
        .rst_n (Reset_n),
        .valid0(bus.ReqValid0),
        .valid1(bus.ReqValid1),
        .grant0(grant0),
        .grant1(grant1)
    );

    assign bus.ReqReady0 = grant0;
    assign bus.ReqReady1 = grant1;
    assign xfer          = grant0 | grant1;

    wb_state_e             state_q;
    wb_state_e             state_d;
    logic                  regwrite_c;
    logic [REG_ADDR_W-1:0] wreg_p1;
    logic [DATA_W-1:0]     wdata_p1;
    logic [7:0]            count_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A transfer always lands in COMMIT next cycle, even from COMMIT, so
    // back-to-back writes flow without a bubble. Register 0 is staged but
    // never enabled.
    always_comb begin
        state_d    = IDLE;
        regwrite_c = 1'b0;
        if (xfer) begin
            state_d = COMMIT;
        end
        if ((state_q == COMMIT) && reg_is_live(wreg_p1)) begin
            regwrite_c = 1'b1;
        end
    end

    // ---- stage p1: accepted request captured for commit ----
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wreg_p1  <= ZERO_REG;
            wdata_p1 <= '0;
        end else if (xfer) begin
            wreg_p1  <= grant1 ? bus.ReqReg1  : bus.ReqReg0;
            wdata_p1 <= grant1 ? bus.ReqData1 : bus.ReqData0;
        end
    end

    // Counts only enabled writes; 8-bit wrap is intentional.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else if (regwrite_c) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign bus.WriteRegister = wreg_p1;
    assign bus.WriteData     = wdata_p1;
    assign bus.RegWrite      = regwrite_c;
    assign bus.WriteCount    = count_q;
    assign bus.Stall         = regwrite_c &&
                               ((bus.ReadRegister1 == wreg_p1) ||
                                (bus.ReadRegister2 == wreg_p1));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Bench for regfile_wb_arbiter: table of directed cycles, hand-written
// corner sequences (stall, fixed priority, reset mid-commit, counter wrap)
// and a randomized run against a behavioural model.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    logic Clk = 1'b0;
    logic Reset_n;
    logic rf_clr;

    always #5 Clk = ~Clk;

    regfile_wb_arbiter_if #(.DATA_W(32)) bus ();
    regfile_wb_arbiter_if #(.DATA_W(32)) bus_f ();

    regfile_wb_arbiter #(.DATA_W(32), .FIXED_PRIO(0)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
    );

    regfile_wb_arbiter #(.DATA_W(32), .FIXED_PRIO(1)) dut_f (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus_f)
    );

    // Register file fed by the write port of the round-robin DUT
    logic [31:0] tb_rf [32];
    always @(posedge Clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) tb_rf[i] <= '0;
        end else if (bus.RegWrite) begin
            tb_rf[bus.WriteRegister] <= bus.WriteData;
        end
    end

    function automatic logic [31:0] rf_read(input int addr);
        return (addr == 0) ? 32'd0 : tb_rf[addr];
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] rr1, input logic [4:0] rr2);
        bus.ReqValid0 = v0; bus.ReqReg0 = r0; bus.ReqData0 = d0;
        bus.ReqValid1 = v1; bus.ReqReg1 = r1; bus.ReqData1 = d1;
        bus.ReadRegister1 = rr1; bus.ReadRegister2 = rr2;
    endtask

    task automatic idle_f();
        bus_f.ReqValid0 = 1'b0; bus_f.ReqReg0 = '0; bus_f.ReqData0 = '0;
        bus_f.ReqValid1 = 1'b0; bus_f.ReqReg1 = '0; bus_f.ReqData1 = '0;
        bus_f.ReadRegister1 = '0; bus_f.ReadRegister2 = '0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        rf_clr  = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        idle_f();
        @(negedge Clk);
        Reset_n = 1'b1;
        rf_clr  = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        v0;  logic [4:0] r0; logic [31:0] d0;
        logic        v1;  logic [4:0] r1; logic [31:0] d1;
        logic [4:0]  rr1; logic [4:0] rr2;
        logic        rdy0; logic rdy1; logic rw;
        logic [4:0]  wr;  logic [31:0] wd; logic st; logic [7:0] cnt;
    } vec_t;

    localparam int NVEC = 11;
    vec_t tbl [NVEC];

    task automatic row(input int i, input int v0, input int r0, input int d0,
                       input int v1, input int r1, input int d1, input int rr1, input int rr2,
                       input int rdy0, input int rdy1, input int rw, input int wr,
                       input int wd, input int st, input int cnt);
        tbl[i].v0 = 1'(v0);   tbl[i].r0 = 5'(r0);   tbl[i].d0 = 32'(d0);
        tbl[i].v1 = 1'(v1);   tbl[i].r1 = 5'(r1);   tbl[i].d1 = 32'(d1);
        tbl[i].rr1 = 5'(rr1); tbl[i].rr2 = 5'(rr2);
        tbl[i].rdy0 = 1'(rdy0); tbl[i].rdy1 = 1'(rdy1); tbl[i].rw = 1'(rw);
        tbl[i].wr = 5'(wr);   tbl[i].wd = 32'(wd);  tbl[i].st = 1'(st);
        tbl[i].cnt = 8'(cnt);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int r; logic [31:0] d; } wb_t;
    wb_t         pend [$];
    int          mdl_last;
    int          mdl_cnt;
    logic [31:0] mdl_rf [32];

    task automatic model_init();
        pend.delete();
        mdl_last = 1;   // so requester 0 wins the first contention
        mdl_cnt  = 0;
        for (int i = 0; i < 32; i++) mdl_rf[i] = '0;
    endtask

    task automatic mcycle(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                          input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                          input logic [4:0] rr1, input logic [4:0] rr2);
        int  win;
        bit  e_rw;
        bit  e_st;
        int  e_reg;
        wb_t w;
        @(negedge Clk);
        drive(v0, r0, d0, v1, r1, d1, rr1, rr2);
        #1;
        if (v0 && v1) win = (mdl_last == 0) ? 1 : 0;
        else if (v0)  win = 0;
        else if (v1)  win = 1;
        else          win = -1;
        e_reg = (pend.size() > 0) ? pend[0].r : 0;
        e_rw  = (pend.size() > 0) && (e_reg != 0);
        e_st  = e_rw && ((int'(rr1) == e_reg) || (int'(rr2) == e_reg));
        check("rnd_ready0", bus.ReqReady0, win == 0);
        check("rnd_ready1", bus.ReqReady1, win == 1);
        check("rnd_regwrite", bus.RegWrite, e_rw);
        check("rnd_stall", bus.Stall, e_st);
        check("rnd_count", bus.WriteCount, mdl_cnt);
        if (pend.size() > 0) begin
            check("rnd_wreg", bus.WriteRegister, pend[0].r);
            check("rnd_wdata", bus.WriteData, pend[0].d);
        end
        // effects of the coming clock edge
        if (e_rw) begin
            mdl_rf[e_reg] = pend[0].d;
            mdl_cnt = (mdl_cnt + 1) % 256;
        end
        pend.delete();
        if (win >= 0) begin
            w.r = (win == 0) ? int'(r0) : int'(r1);
            w.d = (win == 0) ? d0 : d1;
            pend.push_back(w);
            mdl_last = win;
        end
    endtask

    logic [31:0] prev;

    initial begin
        //           v0 r0 d0  v1 r1 d1  rr1 rr2 | rdy0 rdy1 rw wr wd  st cnt
        row(0,       1, 2, 42, 0, 0, 0,  0,  0,    1,   0,   0, 0, 0,  0, 0);
        row(1,       0, 0, 0,  0, 0, 0,  2,  2,    0,   0,   1, 2, 42, 1, 0);
        row(2,       0, 0, 0,  1, 0, 59, 0,  0,    0,   1,   0, 2, 42, 0, 1);
        row(3,       0, 0, 0,  0, 0, 0,  0,  0,    0,   0,   0, 0, 59, 0, 1);
        row(4,       1, 4, 26, 1, 5, 27, 0,  0,    1,   0,   0, 0, 59, 0, 1);
        row(5,       1, 4, 26, 1, 5, 27, 4,  9,    0,   1,   1, 4, 26, 1, 1);
        row(6,       1, 4, 26, 1, 5, 27, 8,  17,   1,   0,   1, 5, 27, 0, 2);
        row(7,       1, 4, 26, 1, 5, 27, 0,  0,    0,   1,   1, 4, 26, 0, 3);
        row(8,       1, 17,77, 0, 0, 0,  0,  0,    1,   0,   1, 5, 27, 0, 4);
        row(9,       0, 0, 0,  0, 0, 0,  8,  17,   0,   0,   1, 17,77, 1, 5);
        row(10,      0, 0, 0,  0, 0, 0,  0,  0,    0,   0,   0, 17,77, 0, 6);

        // ---- reset state ----
        rf_clr  = 1'b1;
        Reset_n = 1'b1;
        drive(1, 3, 9, 1, 4, 9, 0, 0);
        idle_f();
        bus_f.ReqValid0 = 1'b1;
        #1 Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        #1;
        check("rst_ready0", bus.ReqReady0, 0);
        check("rst_ready1", bus.ReqReady1, 0);
        check("rst_regwrite", bus.RegWrite, 0);
        check("rst_wreg", bus.WriteRegister, 0);
        check("rst_wdata", bus.WriteData, 0);
        check("rst_count", bus.WriteCount, 0);
        check("rst_stall", bus.Stall, 0);
        check("rst_f_ready0", bus_f.ReqReady0, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        rf_clr  = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        idle_f();

        // ---- directed table ----
        for (int i = 0; i < NVEC; i++) begin
            @(negedge Clk);
            drive(tbl[i].v0, tbl[i].r0, tbl[i].d0, tbl[i].v1, tbl[i].r1, tbl[i].d1,
                  tbl[i].rr1, tbl[i].rr2);
            #1;
            check($sformatf("tbl%0d_ready0", i), bus.ReqReady0, tbl[i].rdy0);
            check($sformatf("tbl%0d_ready1", i), bus.ReqReady1, tbl[i].rdy1);
            check($sformatf("tbl%0d_regwrite", i), bus.RegWrite, tbl[i].rw);
            check($sformatf("tbl%0d_wreg", i), bus.WriteRegister, tbl[i].wr);
            check($sformatf("tbl%0d_wdata", i), bus.WriteData, tbl[i].wd);
            check($sformatf("tbl%0d_stall", i), bus.Stall, tbl[i].st);
            check($sformatf("tbl%0d_count", i), bus.WriteCount, tbl[i].cnt);
        end
        @(negedge Clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rf_reg2", rf_read(2), 42);
        check("rf_reg4", rf_read(4), 26);
        check("rf_reg5", rf_read(5), 27);
        check("rf_reg17", rf_read(17), 77);
        check("rf_reg0", rf_read(0), 0);

        // ---- stall on either read port, same staged write ----
        @(negedge Clk);
        drive(1, 17, 5, 0, 0, 0, 8, 17);
        @(negedge Clk);
        drive(0, 0, 0, 0, 0, 0, 8, 17);
        #1 check("stall_port2_hit", bus.Stall, 1);
        bus.ReadRegister2 = 5'd23;
        #1 check("stall_no_hit", bus.Stall, 0);
        bus.ReadRegister1 = 5'd17;
        #1 check("stall_port1_hit", bus.Stall, 1);

        // ---- fixed priority: requester 0 always wins ----
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            bus_f.ReqValid0 = 1'b1; bus_f.ReqReg0 = 5'd4; bus_f.ReqData0 = 32'd26;
            bus_f.ReqValid1 = 1'b1; bus_f.ReqReg1 = 5'd5; bus_f.ReqData1 = 32'd27;
            #1;
            check($sformatf("fixed%0d_ready0", i), bus_f.ReqReady0, 1);
            check($sformatf("fixed%0d_ready1", i), bus_f.ReqReady1, 0);
        end
        @(negedge Clk);
        idle_f();

        // ---- reset asserted mid-COMMIT cancels the write ----
        do_reset();
        prev = tb_rf[1];
        drive(1, 1, 59, 0, 0, 0, 1, 0);
        @(negedge Clk);
        drive(1, 1, 59, 0, 0, 0, 1, 0);
        #1 check("midrst_pre_regwrite", bus.RegWrite, 1);
        Reset_n = 1'b0;
        #1;
        check("midrst_regwrite", bus.RegWrite, 0);
        check("midrst_count", bus.WriteCount, 0);
        check("midrst_ready0", bus.ReqReady0, 0);
        check("midrst_stall", bus.Stall, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        drive(1, 6, 11, 1, 7, 12, 0, 0);
        #1;
        check("postrst_ready0", bus.ReqReady0, 1);
        check("postrst_ready1", bus.ReqReady1, 0);
        @(negedge Clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("midrst_reg1_kept", tb_rf[1], prev);
        check("midrst_count_after", bus.WriteCount, 0);

        // ---- 256 commits wrap the counter ----
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1, 3, 32'(i), 0, 0, 0, 0, 0);
            @(negedge Clk);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("wrap_last_regwrite", bus.RegWrite, 1);
        check("wrap_count_255", bus.WriteCount, 255);
        @(negedge Clk);
        #1;
        check("wrap_count_0", bus.WriteCount, 0);
        check("wrap_reg3", rf_read(3), 255);

        // ---- randomized run against the model ----
        do_reset();
        model_init();
        for (int i = 0; i < 600; i++) begin
            mcycle(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        mcycle(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("rnd_rf%0d", i), rf_read(i), mdl_rf[i]);
        end
        check("rnd_final_count", bus.WriteCount, mdl_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
